// File: rtl/sram_pkg.sv
// sram_pkg: shared limits, read-pipe entry and wait-FSM states for sim_sram_pipe
package sram_pkg;
  localparam int rlat_max = 4;
  localparam int wait_max = 15;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rpipe_t;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/sim_sram_pipe_if.sv
// sim_sram_pipe_if: request/response bus between a master and the sim_sram_pipe model
interface sim_sram_pipe_if #(
  parameter int alen = 8,
  parameter int dlen = 32
);
  localparam int blen = dlen / 8;
  logic            req;
  logic            we;
  logic [blen-1:0] wmask;
  logic [alen-1:0] addr;
  logic [dlen-1:0] wdata;
  logic            ready;
  logic            rvalid;
  logic [dlen-1:0] rdata;
  modport master (output req, we, wmask, addr, wdata, input ready, rvalid, rdata);
  modport slave (input req, we, wmask, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/sram_rpipe.sv
// sram_rpipe: rlat-deep valid/data shift register carrying read results to the bus
module sram_rpipe #(
  parameter int  rlat    = 1,
  parameter type entry_t = sram_pkg::rpipe_t
) (
  input  logic   clk,
  input  logic   rst,
  input  entry_t din,
  output entry_t dout
);
  entry_t pipe [rlat];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < rlat; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < rlat; i++) pipe[i] <= pipe[i-1];
    end
  assign dout = pipe[rlat-1];
endmodule

// File: rtl/sim_sram_pipe.sv
// sim_sram_pipe: simulation SRAM with byte-masked writes, rlat-cycle reads and wait states.
// Define SRAM_UNINIT_X_EN to make never-written bytes read back as X instead of 0.
module sim_sram_pipe
  import sram_pkg::*;
#(
  parameter int alen        = 8,
  parameter int dlen        = 32,
  parameter int rlat        = 1,
  parameter int wait_states = 0
) (
  input logic            clk,
  input logic            rst,
  sim_sram_pipe_if.slave bus
);
  localparam int depth = 1 << alen;
  localparam int blen = dlen / 8;
  localparam logic [0:0] st_idle = IDLE;
  localparam logic [0:0] st_busy = BUSY;
  typedef struct packed {
    logic            valid;
    logic [dlen-1:0] data;
  } entry_t;
  if (rlat < 1 || rlat > rlat_max || wait_states < 0 || wait_states > wait_max || dlen % 8 != 0)
  begin : g_bad_param
    $error("sim_sram_pipe: illegal rlat=%0d wait_states=%0d dlen=%0d", rlat, wait_states, dlen);
  end
  logic [0:0]      state;
  logic [3:0]      cnt;
  logic            acc;
  logic [dlen-1:0] rword;
  entry_t          pin, pout;
  assign bus.ready = state == st_idle;
  assign acc = bus.req && bus.ready;
`ifdef SRAM_UNINIT_X_EN
  logic [dlen-1:0] mem [depth];
  logic [blen-1:0] wmap [depth] = '{default: '0};
  always_ff @(posedge clk)
    if (acc && bus.we) wmap[bus.addr] <= wmap[bus.addr] | bus.wmask;
  always_comb begin
    rword = mem[bus.addr];
    for (int i = 0; i < blen; i++) if (!wmap[bus.addr][i]) rword[8*i +: 8] = 'x;
  end
`else
  logic [dlen-1:0] mem [depth] = '{default: '0};
  assign rword = mem[bus.addr];
`endif
  always_ff @(posedge clk)
    if (acc && bus.we)
      for (int i = 0; i < blen; i++)
        if (bus.wmask[i]) mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
  assign pin = {acc && !bus.we, rword};
  sram_rpipe #(.rlat(rlat), .entry_t(entry_t)) u_rpipe (
    .clk (clk),
    .rst (rst),
    .din (pin),
    .dout(pout)
  );
  assign bus.rvalid = pout.valid;
  assign bus.rdata = pout.valid ? pout.data : '0;
  // ready drops for wait_states cycles after every accept; reads keep draining meanwhile
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= st_idle;
      cnt <= '0;
    end else if (state == st_idle) begin
      if (acc && wait_states > 0) begin
        state <= st_busy;
        cnt <= 4'(wait_states);
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) state <= st_idle;
    end
endmodule

// File: tb/tb_sim_sram_pipe.sv
// tb_sim_sram_pipe: directed checks on three sim_sram_pipe configurations (rlat1/ws0, rlat3/ws0, rlat1/ws2)
module tb_sim_sram_pipe;
  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  reqv = '0;
  logic        we = 0;
  logic [3:0]  wmask = '0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sim_sram_pipe_if #(.alen(8), .dlen(32)) i1 ();
  sim_sram_pipe_if #(.alen(8), .dlen(32)) i3 ();
  sim_sram_pipe_if #(.alen(8), .dlen(32)) iw ();
  assign i1.req = reqv[0];
  assign i1.we = we;
  assign i1.wmask = wmask;
  assign i1.addr = addr;
  assign i1.wdata = wdata;
  assign i3.req = reqv[1];
  assign i3.we = we;
  assign i3.wmask = wmask;
  assign i3.addr = addr;
  assign i3.wdata = wdata;
  assign iw.req = reqv[2];
  assign iw.we = we;
  assign iw.wmask = wmask;
  assign iw.addr = addr;
  assign iw.wdata = wdata;
  sim_sram_pipe #(.alen(8), .dlen(32), .rlat(1), .wait_states(0)) d1 (.clk(clk), .rst(rst), .bus(i1));
  sim_sram_pipe #(.alen(8), .dlen(32), .rlat(3), .wait_states(0)) d3 (.clk(clk), .rst(rst), .bus(i3));
  sim_sram_pipe #(.alen(8), .dlen(32), .rlat(1), .wait_states(2)) dw (.clk(clk), .rst(rst), .bus(iw));

  function automatic logic rdy(input int s);
    return s == 0 ? i1.ready : s == 1 ? i3.ready : iw.ready;
  endfunction
  function automatic logic rv(input int s);
    return s == 0 ? i1.rvalid : s == 1 ? i3.rvalid : iw.rvalid;
  endfunction
  function automatic logic [31:0] rd(input int s);
    return s == 0 ? i1.rdata : s == 1 ? i3.rdata : iw.rdata;
  endfunction

  // one accepted access on DUT s; entered and left #1 after a rising edge
  task automatic acc(input int s, input logic w, input logic [3:0] m, input logic [7:0] a, input logic [31:0] d);
    for (int t = 0; t < 40 && !rdy(s); t++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (rdy(s) !== 1'b1) begin
      errors++;
      $display("FAIL acc_wait_ready dut=%0d ready=%b required=1", s, rdy(s));
    end
    we = w;
    wmask = m;
    addr = a;
    wdata = d;
    reqv = 3'b001 << s;
    @(posedge clk);
    #1;
    reqv = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (i1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got=%b exp=1", i1.ready); end
    checks++;
    if (i1.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid1 got=%b exp=0", i1.rvalid); end
    checks++;
    if (i1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", i1.rdata); end
    checks++;
    if (i3.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid3 got=%b exp=0", i3.rvalid); end
    checks++;
    if (iw.ready !== 1'b1) begin errors++; $display("FAIL reset_readyw got=%b exp=1", iw.ready); end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_byte_mask;
    acc(0, 1, 4'b1111, 8'h10, 32'hAABBCCDD);
    acc(0, 1, 4'b0101, 8'h10, 32'h11223344);
    checks++;
    if (rv(0) !== 1'b0) begin errors++; $display("FAIL mask_no_rvalid_on_write got=%b exp=0", rv(0)); end
    acc(0, 0, 4'b0000, 8'h10, 32'h0);
    checks++;
    if (rv(0) !== 1'b1) begin errors++; $display("FAIL mask_rvalid got=%b exp=1", rv(0)); end
    checks++;
    if (rd(0) !== 32'hAA22CC44) begin errors++; $display("FAIL mask_rdata got=%h exp=aa22cc44", rd(0)); end
    @(posedge clk);
    #1;
    checks++;
    if (rv(0) !== 1'b0 || rd(0) !== 32'h0) begin
      errors++;
      $display("FAIL mask_pulse_end rvalid=%b rdata=%h exp=0/0", rv(0), rd(0));
    end
  endtask

  task automatic test_latency;
    logic        ev;
    logic [31:0] ed;
    for (int i = 0; i < 4; i++) acc(1, 1, 4'b1111, 8'(i), 32'(i));
    for (int c = 0; c < 8; c++) begin
      we = 0;
      addr = 8'(c);
      reqv = c < 4 ? 3'b010 : 3'b000;
      checks++;
      if (rdy(1) !== 1'b1) begin errors++; $display("FAIL lat_ready c=%0d got=%b exp=1", c, rdy(1)); end
      @(posedge clk);
      #1;
      ev = c >= 2 && c <= 5;
      ed = ev ? 32'(c - 2) : 32'h0;
      checks++;
      if (rv(1) !== ev || rd(1) !== ed) begin
        errors++;
        $display("FAIL lat_read c=%0d rvalid=%b rdata=%h exp=%b/%h", c, rv(1), rd(1), ev, ed);
      end
    end
    reqv = '0;
  endtask

  task automatic test_wait_states;
    logic        er;
    logic [31:0] ed;
    int          idx = 0;
    for (int i = 0; i < 3; i++) acc(2, 1, 4'b1111, 8'(i), 32'hC0DE0000 | 32'(i));
    for (int t = 0; t < 10 && !rdy(2); t++) begin
      @(posedge clk);
      #1;
    end
    we = 0;
    addr = 8'h0;
    reqv = 3'b100;
    for (int c = 0; c < 9; c++) begin
      er = c % 3 == 0;
      checks++;
      if (rdy(2) !== er) begin errors++; $display("FAIL ws_ready c=%0d got=%b exp=%b", c, rdy(2), er); end
      @(posedge clk);
      #1;
      ed = er ? (32'hC0DE0000 | 32'(idx)) : 32'h0;
      checks++;
      if (rv(2) !== er || rd(2) !== ed) begin
        errors++;
        $display("FAIL ws_read c=%0d rvalid=%b rdata=%h exp=%b/%h", c, rv(2), rd(2), er, ed);
      end
      if (er) begin
        idx++;
        addr = 8'(idx);
      end
    end
    reqv = '0;
  endtask

  task automatic test_reset_mid;
    for (int t = 0; t < 10 && !rdy(2); t++) begin
      @(posedge clk);
      #1;
    end
    we = 0;
    addr = 8'h1;
    reqv = 3'b110;
    @(posedge clk);
    #1;
    reqv = '0;
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    checks++;
    if (rv(1) !== 1'b0 || rdy(1) !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_assert rvalid=%b ready=%b exp=0/1", rv(1), rdy(1));
    end
    checks++;
    if (rdy(2) !== 1'b1) begin errors++; $display("FAIL rstmid_fsm_idle got=%b exp=1", rdy(2)); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rv(1) !== 1'b0 || rdy(1) !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_hold c=%0d rvalid=%b ready=%b exp=0/1", c, rv(1), rdy(1));
      end
    end
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rv(1) !== 1'b0 || rdy(1) !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after c=%0d rvalid=%b ready=%b exp=0/1", c, rv(1), rdy(1));
      end
    end
    acc(1, 0, 4'b0000, 8'h2, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (rv(1) !== 1'b1 || rd(1) !== 32'h2) begin
      errors++;
      $display("FAIL rstmid_readback rvalid=%b rdata=%h exp=1/00000002", rv(1), rd(1));
    end
  endtask

  task automatic test_uninit;
    acc(0, 1, 4'b0001, 8'h5, 32'h000000EE);
    acc(0, 0, 4'b0000, 8'h5, 32'h0);
    checks++;
    if (rv(0) !== 1'b1) begin errors++; $display("FAIL uninit_rvalid got=%b exp=1", rv(0)); end
`ifdef SRAM_UNINIT_X_EN
    checks++;
    if (i1.rdata[7:0] !== 8'hEE) begin errors++; $display("FAIL uninit_lane0 got=%h exp=ee", i1.rdata[7:0]); end
`else
    checks++;
    if (rd(0) !== 32'h000000EE) begin errors++; $display("FAIL uninit_rdata got=%h exp=000000ee", rd(0)); end
`endif
  endtask

  task automatic test_mask_zero;
    acc(2, 1, 4'b1111, 8'h7, 32'h12345678);
    acc(2, 1, 4'b0000, 8'h7, 32'hFFFFFFFF);
    checks++;
    if (rdy(2) !== 1'b0) begin errors++; $display("FAIL mask0_busy0 got=%b exp=0", rdy(2)); end
    @(posedge clk);
    #1;
    checks++;
    if (rdy(2) !== 1'b0) begin errors++; $display("FAIL mask0_busy1 got=%b exp=0", rdy(2)); end
    @(posedge clk);
    #1;
    checks++;
    if (rdy(2) !== 1'b1) begin errors++; $display("FAIL mask0_idle got=%b exp=1", rdy(2)); end
    acc(2, 0, 4'b0000, 8'h7, 32'h0);
    checks++;
    if (rv(2) !== 1'b1 || rd(2) !== 32'h12345678) begin
      errors++;
      $display("FAIL mask0_read rvalid=%b rdata=%h exp=1/12345678", rv(2), rd(2));
    end
  endtask

  initial begin
    test_reset;
    test_byte_mask;
    test_latency;
    test_wait_states;
    test_reset_mid;
    test_uninit;
    test_mask_zero;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
